// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: drives pixel coordinates to the renderer, registers the returned
// colour with matching sync/blank timing, and emits a per-frame strobe.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_pix_en,
   output logic [10:0] o_VGA_X,
   output logic [10:0] o_VGA_Y,
   input  logic [7:0]  i_VGA_R,
   input  logic [7:0]  i_VGA_G,
   input  logic [7:0]  i_VGA_B,
   output logic [7:0]  o_VGA_R,
   output logic [7:0]  o_VGA_G,
   output logic [7:0]  o_VGA_B,
   output logic        o_VGA_HS,
   output logic        o_VGA_VS,
   output logic        o_VGA_BLANK_N,
   output logic        o_VGA_SYNC_N,
   output logic        o_frame_start
);

   localparam int unsigned CW      = 11;
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_ACT_L  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] H_SYNC_S = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] H_SYNC_E = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] V_ACT_L  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] V_SYNC_S = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] V_SYNC_E = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

   if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_range_check
      $error("vga_timing_gen: raster totals exceed 11-bit counter range");
   end

   logic [CW-1:0] h_cnt_q, h_cnt_d;
   logic [CW-1:0] v_cnt_q, v_cnt_d;
   logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
   logic          hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;

   logic h_last, v_last, active0, hs0, vs0;

   // Stage 0 decode: region membership is a pure function of the counters
   always_comb begin
      h_last  = (h_cnt_q == H_LAST);
      v_last  = (v_cnt_q == V_LAST);
      active0 = (h_cnt_q < H_ACT_L) && (v_cnt_q < V_ACT_L);
      hs0     = (h_cnt_q >= H_SYNC_S) && (h_cnt_q <= H_SYNC_E);
      vs0     = (v_cnt_q >= V_SYNC_S) && (v_cnt_q <= V_SYNC_E);
   end

   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (i_pix_en) begin
         if (h_last) begin
            h_cnt_d = '0;
            v_cnt_d = v_last ? '0 : v_cnt_q + CW'(1);
         end else begin
            h_cnt_d = h_cnt_q + CW'(1);
         end
      end
   end

   // Stage 1: colour, blank and syncs share one enabled cycle of latency
   always_comb begin
      r_d       = r_q;
      g_d       = g_q;
      b_d       = b_q;
      blank_n_d = blank_n_q;
      hs_d      = hs_q;
      vs_d      = vs_q;
      if (i_pix_en) begin
         r_d       = active0 ? i_VGA_R : 8'd0;
         g_d       = active0 ? i_VGA_G : 8'd0;
         b_d       = active0 ? i_VGA_B : 8'd0;
         blank_n_d = active0;
         hs_d      = hs0 ? HS_POL : ~HS_POL;
         vs_d      = vs0 ? VS_POL : ~VS_POL;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         r_q       <= '0;
         g_q       <= '0;
         b_q       <= '0;
         blank_n_q <= 1'b0;
         hs_q      <= ~HS_POL;
         vs_q      <= ~VS_POL;
      end else begin
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         r_q       <= r_d;
         g_q       <= g_d;
         b_q       <= b_d;
         blank_n_q <= blank_n_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
      end
   end

   assign o_VGA_X       = active0 ? h_cnt_q : '0;
   assign o_VGA_Y       = active0 ? v_cnt_q : '0;
   assign o_VGA_R       = r_q;
   assign o_VGA_G       = g_q;
   assign o_VGA_B       = b_q;
   assign o_VGA_HS      = hs_q;
   assign o_VGA_VS      = vs_q;
   assign o_VGA_BLANK_N = blank_n_q;
   assign o_VGA_SYNC_N  = 1'b0;
   // Strobe is combinational so it can never appear on a disabled cycle
   assign o_frame_start = i_pix_en & ~i_rst & h_last & v_last;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Horizontal timing is full 800-pixel VGA; the vertical
// timing is shortened (4 active, 1 fp, 2 sync, 2 bp = 9 lines) to keep whole frames short.
module tb_vga_timing_gen;

   localparam int unsigned H_TOTAL = 800;
   localparam int unsigned VA      = 4;
   localparam int unsigned VFP     = 1;
   localparam int unsigned VSY     = 2;
   localparam int unsigned VBP     = 2;
   localparam int unsigned V_TOTAL = VA + VFP + VSY + VBP;
   localparam int unsigned FRAME   = H_TOTAL * V_TOTAL;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pix_en = 1'b1;
   logic        ff_mode = 1'b0;
   logic [10:0] vx, vy;
   logic [7:0]  r_in, g_in, b_in, r_o, g_o, b_o;
   logic        hs, vs, blank_n, sync_n, fs;

   int n_tests = 0;
   int n_fail  = 0;

   // Renderer model: colour is a fixed function of the requested coordinate
   assign r_in = ff_mode ? 8'hFF : vx[7:0];
   assign g_in = ff_mode ? 8'hFF : vy[7:0];
   assign b_in = ff_mode ? 8'hFF : (vx[7:0] ^ vy[7:0] ^ 8'h5A);

   vga_timing_gen #(
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_pix_en(pix_en),
      .o_VGA_X(vx), .o_VGA_Y(vy),
      .i_VGA_R(r_in), .i_VGA_G(g_in), .i_VGA_B(b_in),
      .o_VGA_R(r_o), .o_VGA_G(g_o), .o_VGA_B(b_o),
      .o_VGA_HS(hs), .o_VGA_VS(vs), .o_VGA_BLANK_N(blank_n), .o_VGA_SYNC_N(sync_n),
      .o_frame_start(fs)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      pix_en = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      pix_en = 1'b1;
      step();
      step();
      n_tests++;
      if ({r_o, g_o, b_o} !== 24'h0) begin n_fail++; $display("FAIL reset_rgb: got %h expected 000000", {r_o, g_o, b_o}); end
      n_tests++;
      if ({blank_n, hs, vs, sync_n, fs} !== 5'b01100) begin
         n_fail++; $display("FAIL reset_ctrl: got blank/hs/vs/sync/fs=%b expected 01100", {blank_n, hs, vs, sync_n, fs});
      end
      rst = 1'b0;
      #1;
      n_tests++;
      if ({vx, vy} !== 22'd0) begin n_fail++; $display("FAIL first_coord: got x=%0d y=%0d expected 0,0", vx, vy); end
      step();
      n_tests++;
      if ({blank_n, r_o, g_o, b_o} !== {1'b1, 24'h00005A}) begin
         n_fail++; $display("FAIL first_pixel: got blank=%b rgb=%h expected 1 00005A", blank_n, {r_o, g_o, b_o});
      end
      n_tests++;
      if (vx !== 11'd1) begin n_fail++; $display("FAIL second_x: got %0d expected 1", vx); end
   endtask

   task automatic test_line();
      int hs_low = 0, bl_hi = 0, hs_first = -1;
      do_reset();
      for (int k = 1; k <= int'(H_TOTAL); k++) begin
         step();
         if (hs === 1'b0) begin
            hs_low++;
            if (hs_first < 0) hs_first = k;
         end
         if (blank_n === 1'b1) bl_hi++;
         if (k == 101) begin
            n_tests++;
            if ({r_o, g_o, b_o} !== {8'd100, 8'd0, 8'd100 ^ 8'h5A}) begin
               n_fail++; $display("FAIL pixel_100: got %h expected %h", {r_o, g_o, b_o}, {8'd100, 8'd0, 8'd100 ^ 8'h5A});
            end
         end
      end
      n_tests++;
      if (hs_low !== 96) begin n_fail++; $display("FAIL hs_low_cycles: got %0d expected 96", hs_low); end
      n_tests++;
      if (hs_first !== 657) begin n_fail++; $display("FAIL hs_fall_pos: got %0d expected 657", hs_first); end
      n_tests++;
      if (bl_hi !== 640) begin n_fail++; $display("FAIL blank_hi_cycles: got %0d expected 640", bl_hi); end
      n_tests++;
      if ({vx, vy} !== {11'd0, 11'd1}) begin n_fail++; $display("FAIL line_period: got x=%0d y=%0d expected 0,1", vx, vy); end
   endtask

   task automatic test_frame();
      int vs_low = 0, vs_first = -1, fs_cnt = 0, fs_at = -1;
      do_reset();
      for (int k = 1; k <= int'(FRAME); k++) begin
         step();
         if (vs === 1'b0) begin
            vs_low++;
            if (vs_first < 0) vs_first = k;
         end
         if (fs === 1'b1) begin fs_cnt++; fs_at = k; end
      end
      n_tests++;
      if (vs_low !== 1600) begin n_fail++; $display("FAIL vs_low_cycles: got %0d expected 1600", vs_low); end
      n_tests++;
      if (vs_first !== 4001) begin n_fail++; $display("FAIL vs_fall_pos: got %0d expected 4001", vs_first); end
      n_tests++;
      if (fs_cnt !== 1) begin n_fail++; $display("FAIL frame_strobe_count: got %0d expected 1", fs_cnt); end
      n_tests++;
      if (fs_at !== 7199) begin n_fail++; $display("FAIL frame_strobe_pos: got %0d expected 7199", fs_at); end
      n_tests++;
      if ({vx, vy} !== 22'd0) begin n_fail++; $display("FAIL after_strobe_coord: got x=%0d y=%0d expected 0,0", vx, vy); end
   endtask

   task automatic test_pix_en();
      int fs_cnt = 0, fs_bad = 0, hold_err = 0, fs_j0 = -1, fs_j1 = -1;
      logic [48:0] snap;
      do_reset();
      for (int j = 0; j < 2 * 2 * int'(FRAME) + 10; j++) begin
         pix_en = (j % 2 == 0);
         #1;
         if (fs === 1'b1) begin
            if (!pix_en) fs_bad++;
            else begin
               fs_cnt++;
               if (fs_j0 < 0) fs_j0 = j; else if (fs_j1 < 0) fs_j1 = j;
            end
         end
         snap = {vx, vy, r_o, g_o, b_o, hs, vs, blank_n};
         step();
         if (!pix_en && ({vx, vy, r_o, g_o, b_o, hs, vs, blank_n} !== snap)) hold_err++;
      end
      pix_en = 1'b1;
      n_tests++;
      if (hold_err !== 0) begin n_fail++; $display("FAIL hold_on_disable: got %0d changes expected 0", hold_err); end
      n_tests++;
      if (fs_bad !== 0) begin n_fail++; $display("FAIL strobe_when_disabled: got %0d expected 0", fs_bad); end
      n_tests++;
      if (fs_cnt !== 2) begin n_fail++; $display("FAIL half_rate_strobes: got %0d expected 2", fs_cnt); end
      n_tests++;
      if (fs_j0 !== 14398) begin n_fail++; $display("FAIL half_rate_first_strobe: got %0d expected 14398", fs_j0); end
      n_tests++;
      if (fs_j1 - fs_j0 !== 14400) begin n_fail++; $display("FAIL half_rate_period: got %0d expected 14400", fs_j1 - fs_j0); end
   endtask

   task automatic test_blank_ff();
      do_reset();
      ff_mode = 1'b1;
      step();
      n_tests++;
      if ({blank_n, r_o, g_o, b_o} !== {1'b1, 24'hFFFFFF}) begin
         n_fail++; $display("FAIL active_ff: got blank=%b rgb=%h expected 1 FFFFFF", blank_n, {r_o, g_o, b_o});
      end
      repeat (699) step();
      n_tests++;
      if ({vx, vy} !== 22'd0) begin n_fail++; $display("FAIL blank_coord: got x=%0d y=%0d expected 0,0", vx, vy); end
      step();
      n_tests++;
      if ({blank_n, r_o, g_o, b_o} !== 25'd0) begin
         n_fail++; $display("FAIL blank_ff_masked: got blank=%b rgb=%h expected 0 000000", blank_n, {r_o, g_o, b_o});
      end
      ff_mode = 1'b0;
   endtask

   task automatic test_reset_mid();
      int hs_first = -1, fs_cnt = 0, fs_at = -1;
      do_reset();
      repeat (3 * H_TOTAL + 300) step();
      n_tests++;
      if ({vx, vy} !== {11'd300, 11'd3}) begin n_fail++; $display("FAIL mid_coord: got x=%0d y=%0d expected 300,3", vx, vy); end
      rst = 1'b1;
      pix_en = 1'b0;
      step();
      n_tests++;
      if ({blank_n, r_o, g_o, b_o, hs, vs, sync_n, fs} !== {1'b0, 24'h0, 4'b1100}) begin
         n_fail++; $display("FAIL mid_reset_outputs: got blank=%b rgb=%h hs=%b vs=%b sync=%b fs=%b", blank_n, {r_o, g_o, b_o}, hs, vs, sync_n, fs);
      end
      n_tests++;
      if ({vx, vy} !== 22'd0) begin n_fail++; $display("FAIL mid_reset_coord: got x=%0d y=%0d expected 0,0", vx, vy); end
      rst = 1'b0;
      pix_en = 1'b1;
      for (int k = 1; k <= int'(FRAME); k++) begin
         step();
         if (hs === 1'b0 && hs_first < 0) hs_first = k;
         if (fs === 1'b1) begin fs_cnt++; fs_at = k; end
         if (k == int'(H_TOTAL)) begin
            n_tests++;
            if ({vx, vy} !== {11'd0, 11'd1}) begin n_fail++; $display("FAIL restart_line: got x=%0d y=%0d expected 0,1", vx, vy); end
         end
      end
      n_tests++;
      if (hs_first !== 657) begin n_fail++; $display("FAIL restart_hs_pos: got %0d expected 657", hs_first); end
      n_tests++;
      if ({fs_cnt, fs_at} !== {32'd1, 32'd7199}) begin
         n_fail++; $display("FAIL restart_frame: got count=%0d pos=%0d expected 1 7199", fs_cnt, fs_at);
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_frame();
      test_pix_en();
      test_blank_ff();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
